// File: rtl/buzzer_pkg.sv
// Shared constants, note encoding, FSM state type and half-period helper
// for the buzzer tone generator.
package buzzer_pkg;

  localparam int unsigned FREQ_DO_CHZ  = 26163;
  localparam int unsigned FREQ_RE_CHZ  = 29366;
  localparam int unsigned FREQ_MI_CHZ  = 32963;
  localparam int unsigned FREQ_SOL_CHZ = 39200;
  localparam int unsigned FREQ_LA_CHZ  = 44000;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_DO   = 3'd1;
  localparam logic [2:0] NOTE_RE   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_SOL  = 3'd4;
  localparam logic [2:0] NOTE_LA   = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Half-period in clock cycles; 64-bit math since CLK_FREQ*50 overflows 32 bits.
  function automatic int unsigned half_period(input longint unsigned clk_freq,
                                              input longint unsigned freq_chz);
    longint unsigned q;
    q = (clk_freq * 64'd50) / freq_chz;
    return q[31:0];
  endfunction

endpackage

// File: rtl/buzzer_tone_gen_tone_divider.sv
// Square-wave divider: toggles the output every (half_m1_i + 1) cycles;
// restart_i holds the counter and output at phase 0.
module tone_divider
  import buzzer_pkg::*;
#(
  parameter int unsigned CNT_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] half_m1_i,
  output logic             square_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sq_d  = sq_q;
    if (restart_i) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (cnt_q >= half_m1_i) begin
      cnt_d = '0;
      sq_d  = ~sq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign square_o = sq_q;

endmodule

// File: rtl/buzzer_tone_gen.sv
// Piezo buzzer note player: priority-encodes five buttons, latches a note and
// enforces a minimum sounding time. `define BUZZER_OCTAVE_UP_EN adds btn_oct.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned MIN_NOTE_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnC,
  input  logic       btnR,
  input  logic       btnD,
`ifdef BUZZER_OCTAVE_UP_EN
  input  logic       btn_oct,
`endif
  output logic       buzzer,
  output logic       note_active,
  output logic [2:0] note_idx
);

  localparam int unsigned HALF_DO  = half_period(64'(CLK_FREQ), 64'(FREQ_DO_CHZ));
  localparam int unsigned HALF_RE  = half_period(64'(CLK_FREQ), 64'(FREQ_RE_CHZ));
  localparam int unsigned HALF_MI  = half_period(64'(CLK_FREQ), 64'(FREQ_MI_CHZ));
  localparam int unsigned HALF_SOL = half_period(64'(CLK_FREQ), 64'(FREQ_SOL_CHZ));
  localparam int unsigned HALF_LA  = half_period(64'(CLK_FREQ), 64'(FREQ_LA_CHZ));
  localparam int unsigned CNT_W    = $clog2(HALF_DO);
  localparam int unsigned HOLD_W   = $clog2(MIN_NOTE_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_NOTE_CYCLES);

  state_t            state_q, state_d;
  logic [2:0]        note_q, note_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              oct_q, oct_in;
  logic              load, restart;
  logic [2:0]        sel;
  logic [31:0]       half_full;
  logic [CNT_W-1:0]  half_m1;

`ifdef BUZZER_OCTAVE_UP_EN
  assign oct_in = btn_oct;
`else
  assign oct_in = 1'b0;
`endif

  always_comb begin
    sel = NOTE_NONE;
    if      (btnU) sel = NOTE_DO;
    else if (btnL) sel = NOTE_RE;
    else if (btnC) sel = NOTE_MI;
    else if (btnR) sel = NOTE_SOL;
    else if (btnD) sel = NOTE_LA;
  end

  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    hold_d  = hold_q;
    load    = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        restart = 1'b1;
        if (sel != NOTE_NONE) begin
          state_d = PLAY;
          note_d  = sel;
          hold_d  = '0;
          load    = 1'b1;
        end
      end
      PLAY: begin
        if (sel != NOTE_NONE && sel != note_q) begin
          note_d  = sel;
          hold_d  = '0;
          load    = 1'b1;
          restart = 1'b1;
        // hold_inc counts the current cycle, so a tap sounds exactly MIN_NOTE_CYCLES
        end else if (sel == NOTE_NONE && hold_inc == HOLD_MAX) begin
          state_d = IDLE;
          note_d  = NOTE_NONE;
          hold_d  = '0;
          restart = 1'b1;
        end else begin
          hold_d  = hold_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      note_q  <= NOTE_NONE;
      hold_q  <= '0;
      oct_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      hold_q  <= hold_d;
      if (load) oct_q <= oct_in;
    end
  end

  always_comb begin
    unique case (note_q)
      NOTE_DO:  half_full = HALF_DO;
      NOTE_RE:  half_full = HALF_RE;
      NOTE_MI:  half_full = HALF_MI;
      NOTE_SOL: half_full = HALF_SOL;
      NOTE_LA:  half_full = HALF_LA;
      default:  half_full = HALF_DO;
    endcase
    half_m1 = CNT_W'((half_full >> oct_q) - 32'd1);
  end

  tone_divider #(.CNT_W(CNT_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .half_m1_i (half_m1),
    .square_o  (buzzer)
  );

  assign note_active = (state_q == PLAY);
  assign note_idx    = note_q;

endmodule
